// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: iterative radix-2 divide sequencer for the EX stage.
// Handles DIV.W, MOD.W, DIV.WU and MOD.WU. It works on operand magnitudes
// using a restoring shift-subtract loop, applies the sign fix-up on the
// final step, and holds the registered result until EX consumes it.
// Op encoding: 00=div_w, 01=mod_w, 10=div_wu, 11=mod_wu.
// CNT_WIDTH must satisfy 2**CNT_WIDTH > DATA_WIDTH.
module div_seq_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6,
  parameter bit ZERO_FAST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] src1,
  input  logic [DATA_WIDTH-1:0] src2,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  busy
);

  localparam int W = DATA_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] cnt;
  // dq starts as the dividend magnitude. Each step shifts one dividend bit
  // out of the top and one quotient bit in at the bottom, so dq ends up
  // holding the quotient.
  logic [W-1:0]         dq;
  logic [W-1:0]         rem;
  logic [W-1:0]         dsr;
  logic                 rem_sel;
  logic                 q_neg;
  logic                 r_neg;
  logic [W-1:0]         result_q;

  // Values used when a new operation is loaded.
  logic         accept;
  logic         is_signed;
  logic         sign1;
  logic         sign2;
  logic         src2_zero;
  logic [W-1:0] mag1;
  logic [W-1:0] mag2;
  logic [W-1:0] zero_result;

  // Values produced by one iteration of the loop.
  logic [W:0]   shifted;
  logic [W:0]   diff;
  logic         q_bit;
  logic [W-1:0] rem_step;
  logic [W-1:0] quo_step;
  logic [W-1:0] final_result;

  assign in_ready  = resetn & ((state == S_IDLE) | ((state == S_DONE) & out_ready));
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);
  assign result    = result_q;
  assign accept    = in_valid & in_ready & ~flush;

  // Operand preparation: sign detection, magnitudes, and the zero-divisor result.
  always_comb begin
    // NOTE: give every combinational output a default first. A path that
    // leaves one unassigned would infer a latch.
    is_signed   = ~op[1];
    sign1       = is_signed & src1[W-1];
    sign2       = is_signed & src2[W-1];
    src2_zero   = (src2 == '0);
    mag1        = sign1 ? -src1 : src1;
    mag2        = sign2 ? -src2 : src2;
    zero_result = op[0] ? src1 : '1;
  end

  // One restoring step. The partial remainder is kept at W+1 bits here
  // because a divisor of 2^(W-1) or more can make the shifted value overflow W bits.
  always_comb begin
    shifted  = {rem, dq[W-1]};
    diff     = shifted - {1'b0, dsr};
    q_bit    = ~diff[W];
    rem_step = q_bit ? diff[W-1:0] : shifted[W-1:0];
    quo_step = {dq[W-2:0], q_bit};
    if (rem_sel) final_result = r_neg ? -rem_step : rem_step;
    else         final_result = q_neg ? -quo_step : quo_step;
  end

  // Sequencer state, datapath registers and result register.
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so that every
    // register samples values from before the clock edge.
    if (!resetn) begin
      state    <= S_IDLE;
      cnt      <= '0;
      dq       <= '0;
      rem      <= '0;
      dsr      <= '0;
      rem_sel  <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      result_q <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else if (accept) begin
      // A new op can be accepted from IDLE, or from DONE in the same cycle
      // that the previous result is consumed.
      cnt     <= '0;
      dq      <= mag1;
      rem     <= '0;
      dsr     <= mag2;
      rem_sel <= op[0];
      // A zero divisor must give an all-ones quotient even when the
      // dividend is negative, so the quotient negate is suppressed for it.
      // The remainder fix-up still restores src1 from |src1|.
      q_neg   <= (sign1 ^ sign2) & ~src2_zero;
      r_neg   <= sign1;
      if (ZERO_FAST && src2_zero) begin
        result_q <= zero_result;
        state    <= S_DONE;
      end else begin
        state <= S_CALC;
      end
    end else begin
      case (state)
        S_CALC: begin
          dq  <= quo_step;
          rem <= rem_step;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            result_q <= final_result;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        S_IDLE: ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed and randomized checks of div_seq_ctrl against
// an arithmetic reference model.
module tb_div_seq_ctrl;

  localparam int W = 32;

  logic         clk;
  logic         resetn;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  div_seq_ctrl #(.DATA_WIDTH(W), .CNT_WIDTH(6), .ZERO_FAST(1'b1)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model based on the LoongArch division semantics.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     r;
    if (b == 32'd0) return o[0] ? a : 32'hFFFF_FFFF;
    if (!o[1]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r  = o[0] ? sa % sb : sa / sb;
    end else begin
      ua = {32'd0, a};
      ub = {32'd0, b};
      r  = o[0] ? ua % ub : ua / ub;
    end
    return r[31:0];
  endfunction

  // Waits for out_valid and returns the number of edges after the accept edge.
  task automatic wait_result(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
  endtask

  // Runs one operation from IDLE, holds the result for a few cycles, then consumes it.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    int          n;
    logic [31:0] exp;
    exp      = model(o, a, b);
    in_valid = 1'b1;
    op       = o;
    src1     = a;
    src2     = b;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    op       = 2'($urandom);
    src1     = $urandom;
    src2     = $urandom;
    wait_result(n);
    check({tag, ".latency"}, 32'(n), (b == 32'd0) ? 32'd0 : 32'd32);
    check({tag, ".result"}, result, exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".hold_result"}, result, exp);
      check({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".consumed_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".consumed_busy"}, 32'(busy), 32'd0);
  endtask

  // Counts cycles in which out_valid is seen over a window.
  task automatic count_valid(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (out_valid) seen++;
    end
  endtask

  initial begin
    int          n;
    int          seen;
    logic [1:0]  ro;
    logic [31:0] ra, rb, exp;

    resetn    = 1'b0;
    in_valid  = 1'b0;
    op        = 2'd0;
    src1      = '0;
    src2      = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.result", result, 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.in_ready", 32'(in_ready), 32'd0);
    resetn = 1'b1;
    #1;
    check("post_reset.in_ready", 32'(in_ready), 32'd1);

    // Directed cases.
    run_op("div_w_100_7", 2'b00, 32'd100, 32'd7, 3);
    run_op("mod_w_100_7", 2'b01, 32'd100, 32'd7, 0);
    run_op("div_w_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 1);
    run_op("mod_w_m7_2", 2'b01, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("div_wu_max_2", 2'b10, 32'hFFFF_FFFF, 32'd2, 0);
    run_op("mod_wu_max_2", 2'b11, 32'hFFFF_FFFF, 32'd2, 0);
    run_op("div_w_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("mod_w_ovf", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("div_wu_5_0", 2'b10, 32'd5, 32'd0, 1);
    run_op("mod_wu_5_0", 2'b11, 32'd5, 32'd0, 0);
    run_op("div_w_m5_0", 2'b00, 32'hFFFF_FFFB, 32'd0, 0);
    run_op("mod_w_m5_0", 2'b01, 32'hFFFF_FFFB, 32'd0, 0);
    run_op("mod_wu_big", 2'b11, 32'hFFFF_FFFE, 32'h8000_0001, 0);

    // Hold in DONE for 10 cycles, then accept a new op in the same cycle as consumption.
    in_valid = 1'b1; op = 2'b00; src1 = 32'd1000; src2 = 32'd3;
    tick();
    in_valid = 1'b0;
    wait_result(n);
    check("b2b.first_latency", 32'(n), 32'd32);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("b2b.hold_valid", 32'(out_valid), 32'd1);
      check("b2b.hold_result", result, 32'd333);
      check("b2b.hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1; in_valid = 1'b1; op = 2'b11; src1 = 32'd1000; src2 = 32'd7;
    #1;
    check("b2b.in_ready", 32'(in_ready), 32'd1);
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    check("b2b.busy", 32'(busy), 32'd1);
    wait_result(n);
    check("b2b.second_latency", 32'(n), 32'd32);
    check("b2b.second_result", result, 32'd6);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Flush in CALC when cnt reaches 10.
    in_valid = 1'b1; op = 2'b00; src1 = 32'd12345; src2 = 32'd11;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush.busy", 32'(busy), 32'd0);
    check("flush.in_ready", 32'(in_ready), 32'd1);
    check("flush.out_valid", 32'(out_valid), 32'd0);
    count_valid(40, seen);
    check("flush.no_output", 32'(seen), 32'd0);

    // Flush together with in_valid in IDLE: the request is not taken.
    in_valid = 1'b1; flush = 1'b1; op = 2'b10; src1 = 32'd50; src2 = 32'd5;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle.busy", 32'(busy), 32'd0);
    count_valid(40, seen);
    check("flush_idle.no_output", 32'(seen), 32'd0);

    // Flush in DONE together with consumption.
    in_valid = 1'b1; op = 2'b10; src1 = 32'd7; src2 = 32'd0;
    tick();
    in_valid = 1'b0;
    check("flush_done.valid", 32'(out_valid), 32'd1);
    check("flush_done.result", result, 32'hFFFF_FFFF);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    check("flush_done.out_valid", 32'(out_valid), 32'd0);
    check("flush_done.busy", 32'(busy), 32'd0);

    // Reset asserted mid-CALC for one cycle.
    in_valid = 1'b1; op = 2'b00; src1 = 32'd999; src2 = 32'd4;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    resetn = 1'b0;
    #1;
    check("mid_reset.in_ready_low", 32'(in_ready), 32'd0);
    tick();
    check("mid_reset.out_valid", 32'(out_valid), 32'd0);
    check("mid_reset.result", result, 32'd0);
    check("mid_reset.busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    #1;
    check("mid_reset.in_ready_high", 32'(in_ready), 32'd1);
    count_valid(40, seen);
    check("mid_reset.no_output", 32'(seen), 32'd0);
    run_op("after_reset_9_3", 2'b00, 32'd9, 32'd3, 0);

    // Randomized operations.
    for (int k = 0; k < 40; k++) begin
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: ra = $urandom_range(0, 1000);
        1: ra = 32'h8000_0000;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 15);
        2: rb = 32'hFFFF_FFFF;
        3: rb = 32'h8000_0000 | $urandom;
        default: rb = $urandom;
      endcase
      exp = model(ro, ra, rb);
      in_valid = 1'b1; op = ro; src1 = ra; src2 = rb;
      tick();
      in_valid = 1'b0;
      src1 = $urandom; src2 = $urandom;
      wait_result(n);
      check("rand.latency", 32'(n), (rb == 32'd0) ? 32'd0 : 32'd32);
      check("rand.result", result, exp);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
